mmio_port_fifo: RTL

- Buffered peripheral bound to one MMIO port pair of the MMIO controller, directly downstream of it.
- Consumes the port's even/odd output words and its write/read inform strobes, and supplies the port's two input words.
- CPU writes to the even word go into a TX FIFO that drains to an external valid/ready consumer.
- An external valid/ready producer fills an RX FIFO that the CPU pops by reading the port.

---
 rtl/mmio_port_fifo.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_port_fifo.sv
// mmio_port_fifo: TX/RX FIFO peripheral on one MMIO port pair (optional irq via MMIO_PORT_FIFO_IRQ_EN).
// Latency: TX word pushed at edge N is on tx_data after N; RX head/status are combinational from FIFO state.
// Backpressure: TX push into a full FIFO is dropped and flagged; rx_ready drops while the RX FIFO is full.

// Circular buffer with a flush that takes priority over pop and still accepts a same-cycle push.
module mmio_port_fifo_buf #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_dat,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt,
    output logic          full,
    output logic          empty
);
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wr_addr;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en;

    // Next pointers/count; caller only pushes when not full (or flushing) and pops when not empty.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = wptr_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            cnt_d   = '0;
            wr_addr = '0;
            if (push) begin
                wr_en  = 1'b1;
                wptr_d = AW'(1);
                cnt_d  = CW'(1);
            end
        end else begin
            if (push) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign head_dat  = mem_q[rptr_q];
    assign count     = cnt_q;
    assign count_nxt = cnt_d;
    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
endmodule

module mmio_port_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_out_even,
    input  logic [15:0] port_out_odd,
    input  logic        port_write,
    input  logic        port_read,
    output logic [15:0] port_in_even,
    output logic [15:0] port_in_odd,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready
`ifdef MMIO_PORT_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);
    logic [15:0]         tx_head, rx_head;
    logic [DEPTH_LOG2:0] tx_cnt, tx_cnt_nxt, rx_cnt, rx_cnt_nxt;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic                cmd_clr, cmd_txf, cmd_rxf;
    logic                tx_push, tx_pop, tx_ovf_evt;
    logic                rx_push, rx_pop, rx_unf_evt;
    logic                tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic [1:0]          ie_bits;

    assign cmd_clr = port_write & port_out_odd[0];
    assign cmd_txf = port_write & port_out_odd[1];
    assign cmd_rxf = port_write & port_out_odd[2];

    // A flush in the same strobe frees the FIFO, so the push is never rejected then.
    assign tx_push    = port_write & (~tx_full | cmd_txf);
    assign tx_ovf_evt = port_write & tx_full & ~cmd_txf;
    assign tx_pop     = tx_valid & tx_ready;

    assign rx_ready   = ~rx_full;
    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop     = port_read & ~rx_empty;
    assign rx_unf_evt = port_read & rx_empty;

    mmio_port_fifo_buf #(.W(16), .AW(DEPTH_LOG2)) u_tx (
        .clk(clk), .rst(rst), .flush(cmd_txf), .push(tx_push), .pop(tx_pop),
        .wr_dat(port_out_even), .head_dat(tx_head), .count(tx_cnt),
        .count_nxt(tx_cnt_nxt), .full(tx_full), .empty(tx_empty)
    );

    mmio_port_fifo_buf #(.W(16), .AW(DEPTH_LOG2)) u_rx (
        .clk(clk), .rst(rst), .flush(cmd_rxf), .push(rx_push), .pop(rx_pop),
        .wr_dat(rx_data), .head_dat(rx_head), .count(rx_cnt),
        .count_nxt(rx_cnt_nxt), .full(rx_full), .empty(rx_empty)
    );

    // Sticky error flags: clear first, then a new event in the same cycle wins.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (cmd_clr) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
        if (tx_ovf_evt) tx_ovf_d = 1'b1;
        if (rx_unf_evt) rx_unf_d = 1'b1;
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

`ifdef MMIO_PORT_FIFO_IRQ_EN
    logic ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d, irq_q, irq_d;

    // Interrupt enables load on every write; irq looks at post-update FIFO state.
    always_comb begin
        ie_rx_d = ie_rx_q;
        ie_tx_d = ie_tx_q;
        if (port_write) begin
            ie_rx_d = port_out_odd[4];
            ie_tx_d = port_out_odd[5];
        end
        irq_d = (ie_rx_d & (rx_cnt_nxt != '0)) | (ie_tx_d & (tx_cnt_nxt == '0));
    end

    // Interrupt enable and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_rx_q <= 1'b0;
            ie_tx_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ie_rx_q <= ie_rx_d;
            ie_tx_q <= ie_tx_d;
            irq_q   <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign ie_bits = {ie_tx_q, ie_rx_q};
    wire unused_cmd = ^{port_out_odd[15:6], port_out_odd[3]};
`else
    assign ie_bits = 2'b00;
    wire unused_cmd = ^{port_out_odd[15:3], tx_cnt, tx_cnt_nxt, rx_cnt_nxt};
`endif

    assign tx_valid     = ~tx_empty;
    assign tx_data      = tx_empty ? 16'h0000 : tx_head;
    assign port_in_odd  = rx_empty ? 16'h0000 : rx_head;
    assign port_in_even = {8'(rx_cnt), ie_bits, rx_unf_q, tx_ovf_q,
                           rx_empty, rx_full, tx_empty, tx_full};
endmodule
